warp_mem_arbiter: RTL

Shares the data-memory channels of a dual-warp core between all per-thread LSUs of both warps. Each LSU port is a consumer; each memory channel runs its own request/relay state machine. Free channels are assigned to pending consumers in round-robin order. The block sits between the per-warp LSU arrays and the data-memory/cache interface, replacing the per-warp private data-memory ports.

---
 rtl/gpu_pkg.sv | 14 +
 rtl/warp_mem_arbiter_if.sv | 38 +++
 rtl/rr_first_set.sv | 26 ++
 rtl/warp_mem_arbiter.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// gpu_pkg: channel state encoding and consumer-to-warp mapping shared by the memory arbiter.
package gpu_pkg;
    typedef enum logic [2:0] {
        CH_IDLE,
        CH_READ_WAIT,
        CH_WRITE_WAIT,
        CH_READ_RELAY,
        CH_WRITE_RELAY
    } mem_chan_state_t;

    function automatic int warp_of(input int idx, input int tpb);
        return idx / tpb;
    endfunction
endpackage

// File: rtl/warp_mem_arbiter_if.sv
// warp_mem_arbiter_if: LSU-side and memory-side buses of the shared data-memory arbiter.
interface warp_mem_arbiter_if #(
    parameter int N            = 8,
    parameter int NUM_CHANNELS = 1,
    parameter int ADDR_BITS    = 8,
    parameter int DATA_BITS    = 8
);
    logic [N-1:0]                           lsu_read_valid;
    logic [N-1:0][ADDR_BITS-1:0]            lsu_read_address;
    logic [N-1:0]                           lsu_read_ready;
    logic [N-1:0][DATA_BITS-1:0]            lsu_read_data;
    logic [N-1:0]                           lsu_write_valid;
    logic [N-1:0][ADDR_BITS-1:0]            lsu_write_address;
    logic [N-1:0][DATA_BITS-1:0]            lsu_write_data;
    logic [N-1:0]                           lsu_write_ready;
    logic [NUM_CHANNELS-1:0]                mem_read_valid;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mem_read_address;
    logic [NUM_CHANNELS-1:0]                mem_read_ready;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mem_read_data;
    logic [NUM_CHANNELS-1:0]                mem_write_valid;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mem_write_address;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mem_write_data;
    logic [NUM_CHANNELS-1:0]                mem_write_ready;

    modport slave (
        input  lsu_read_valid, lsu_read_address, lsu_write_valid, lsu_write_address, lsu_write_data,
        output lsu_read_ready, lsu_read_data, lsu_write_ready,
        output mem_read_valid, mem_read_address, mem_write_valid, mem_write_address, mem_write_data,
        input  mem_read_ready, mem_read_data, mem_write_ready
    );

    modport master (
        output lsu_read_valid, lsu_read_address, lsu_write_valid, lsu_write_address, lsu_write_data,
        input  lsu_read_ready, lsu_read_data, lsu_write_ready,
        input  mem_read_valid, mem_read_address, mem_write_valid, mem_write_address, mem_write_data,
        output mem_read_ready, mem_read_data, mem_write_ready
    );
endinterface

// File: rtl/rr_first_set.sv
// rr_first_set: finds the first set request bit at or after ptr_i, wrapping modulo N.
module rr_first_set #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic         found_o,
    output logic [W-1:0] idx_o
);
    logic [W-1:0] j;

    // Scan from the farthest offset down so the nearest hit is the last write.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        j       = '0;
        for (int i = N - 1; i >= 0; i--) begin
            j = W'((int'(ptr_i) + i) % N);
            if (req_i[j]) begin
                found_o = 1'b1;
                idx_o   = j;
            end
        end
    end
endmodule

// File: rtl/warp_mem_arbiter.sv
// warp_mem_arbiter: round-robin sharing of data-memory channels among the LSUs of both warps.
module warp_mem_arbiter
    import gpu_pkg::*;
#(
    parameter int THREADS_PER_BLOCK = 4,
    parameter int NUM_WARPS         = 2,
    parameter int NUM_CHANNELS      = 1,
    parameter int ADDR_BITS         = 8,
    parameter int DATA_BITS         = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    warp_mem_arbiter_if.slave    bus,
    output logic [NUM_WARPS-1:0] warp_busy_o
);
    localparam int N  = NUM_WARPS * THREADS_PER_BLOCK;
    localparam int CW = N > 1 ? $clog2(N) : 1;

    mem_chan_state_t                        state_q [NUM_CHANNELS];
    mem_chan_state_t                        state_d [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0][CW-1:0]        cons_q, cons_d;
    logic [N-1:0]                           claimed_q, claimed_d;
    logic [CW-1:0]                          rr_q, rr_d;
    logic [NUM_CHANNELS-1:0]                mrv_q, mrv_d, mwv_q, mwv_d;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mra_q, mra_d, mwa_q, mwa_d;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mwd_q, mwd_d;
    logic [N-1:0]                           lrr_q, lrr_d, lwr_q, lwr_d;
    logic [N-1:0][DATA_BITS-1:0]            lrd_q, lrd_d;
    logic [NUM_WARPS-1:0]                   busy_q, busy_d;
    logic [N-1:0]                           pending;
    logic [NUM_CHANNELS-1:0]                grant;
    logic [NUM_CHANNELS-1:0][CW-1:0]        pick;

    assign pending = (bus.lsu_read_valid | bus.lsu_write_valid) & ~claimed_q;

    // Each channel sees the pending mask minus whatever lower channels took this cycle.
    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
        logic [N-1:0]  req, nxt;
        logic          found, gnt;
        logic [CW-1:0] idx;
        if (c == 0) begin : g_first
            assign req = pending;
        end else begin : g_next
            assign req = g_ch[c-1].nxt;
        end
        rr_first_set #(.N(N), .W(CW)) u_rr (.req_i(req), .ptr_i(rr_q), .found_o(found), .idx_o(idx));
        assign gnt     = found && state_q[c] == CH_IDLE;
        assign nxt     = req & ~(gnt ? N'(1) << idx : '0);
        assign grant[c] = gnt;
        assign pick[c]  = idx;
    end

    always_comb begin
        state_d   = state_q;
        cons_d    = cons_q;
        claimed_d = claimed_q;
        rr_d      = rr_q;
        mrv_d     = mrv_q;
        mwv_d     = mwv_q;
        mra_d     = mra_q;
        mwa_d     = mwa_q;
        mwd_d     = mwd_q;
        lrr_d     = lrr_q;
        lwr_d     = lwr_q;
        lrd_d     = lrd_q;
        busy_d    = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            case (state_q[c])
                CH_IDLE: if (grant[c]) begin
                    cons_d[c]          = pick[c];
                    claimed_d[pick[c]] = 1'b1;
                    rr_d               = CW'((int'(pick[c]) + 1) % N);
                    if (bus.lsu_read_valid[pick[c]]) begin
                        state_d[c] = CH_READ_WAIT;
                        mrv_d[c]   = 1'b1;
                        mra_d[c]   = bus.lsu_read_address[pick[c]];
                    end else begin
                        state_d[c] = CH_WRITE_WAIT;
                        mwv_d[c]   = 1'b1;
                        mwa_d[c]   = bus.lsu_write_address[pick[c]];
                        mwd_d[c]   = bus.lsu_write_data[pick[c]];
                    end
                end
                CH_READ_WAIT: if (bus.mem_read_ready[c]) begin
                    state_d[c]         = CH_READ_RELAY;
                    mrv_d[c]           = 1'b0;
                    lrd_d[cons_q[c]]   = bus.mem_read_data[c];
                    lrr_d[cons_q[c]]   = 1'b1;
                end
                CH_WRITE_WAIT: if (bus.mem_write_ready[c]) begin
                    state_d[c]         = CH_WRITE_RELAY;
                    mwv_d[c]           = 1'b0;
                    lwr_d[cons_q[c]]   = 1'b1;
                end
                CH_READ_RELAY: if (!bus.lsu_read_valid[cons_q[c]]) begin
                    state_d[c]           = CH_IDLE;
                    lrr_d[cons_q[c]]     = 1'b0;
                    claimed_d[cons_q[c]] = 1'b0;
                end
                CH_WRITE_RELAY: if (!bus.lsu_write_valid[cons_q[c]]) begin
                    state_d[c]           = CH_IDLE;
                    lwr_d[cons_q[c]]     = 1'b0;
                    claimed_d[cons_q[c]] = 1'b0;
                end
                default: state_d[c] = CH_IDLE;
            endcase
        end
        for (int c = 0; c < NUM_CHANNELS; c++)
            for (int w = 0; w < NUM_WARPS; w++)
                if (state_d[c] != CH_IDLE && warp_of(int'(cons_d[c]), THREADS_PER_BLOCK) == w) busy_d[w] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= '{default: CH_IDLE};
            cons_q    <= '0;
            claimed_q <= '0;
            rr_q      <= '0;
            mrv_q     <= '0;
            mwv_q     <= '0;
            mra_q     <= '0;
            mwa_q     <= '0;
            mwd_q     <= '0;
            lrr_q     <= '0;
            lwr_q     <= '0;
            lrd_q     <= '0;
            busy_q    <= '0;
        end else begin
            state_q   <= state_d;
            cons_q    <= cons_d;
            claimed_q <= claimed_d;
            rr_q      <= rr_d;
            mrv_q     <= mrv_d;
            mwv_q     <= mwv_d;
            mra_q     <= mra_d;
            mwa_q     <= mwa_d;
            mwd_q     <= mwd_d;
            lrr_q     <= lrr_d;
            lwr_q     <= lwr_d;
            lrd_q     <= lrd_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.mem_read_valid    = mrv_q;
    assign bus.mem_read_address  = mra_q;
    assign bus.mem_write_valid   = mwv_q;
    assign bus.mem_write_address = mwa_q;
    assign bus.mem_write_data    = mwd_q;
    assign bus.lsu_read_ready    = lrr_q;
    assign bus.lsu_read_data     = lrd_q;
    assign bus.lsu_write_ready   = lwr_q;
    assign warp_busy_o           = busy_q;
endmodule
